// File: rtl/sw_event_reader_pkg.sv
// Shared board I/O widths and the switch event record used by the event reader and its queue.
package sw_event_reader_pkg;

    localparam int SW_W  = 8;
    localparam int CNT_W = 24;

    typedef logic [SW_W-1:0] sw_vec_t;

    // Field order sets the packed layout: sw in the top byte, fall in the bottom byte.
    typedef struct packed {
        sw_vec_t sw;
        sw_vec_t rise;
        sw_vec_t fall;
    } sw_event_t;

    localparam int EV_W = $bits(sw_event_t);

    function automatic sw_event_t make_event(input sw_vec_t new_vec, input sw_vec_t old_vec);
        sw_event_t ev;
        ev.sw   = new_vec;
        ev.rise = new_vec & ~old_vec;
        ev.fall = ~new_vec & old_vec;
        return ev;
    endfunction

endpackage

// File: rtl/sw_event_reader_fifo.sv
// ev_fifo: small register-based FIFO with an extra pointer bit for full/empty detection.
module ev_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // When full, a simultaneous pop frees the head slot, which is the one being written.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) begin
            wr_d = wr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/sw_event_reader.sv
// Switch debouncer: synchronizes, qualifies stable vectors and queues rise/fall change events.
module sw_event_reader
    import sw_event_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw_i,
    output logic [SW_W-1:0] stable_o,
    output logic            ev_valid_o,
    input  logic            ev_ready_i,
    output logic [SW_W-1:0] ev_sw_o,
    output logic [SW_W-1:0] ev_rise_o,
    output logic [SW_W-1:0] ev_fall_o,
    output logic            overflow_o,
    input  logic            ov_clr_i
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    sw_vec_t          s1_q, s2_q;
    sw_vec_t          cand_q, cand_d;
    sw_vec_t          stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overflow_q, overflow_d;
    logic             qualify;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;
    sw_event_t        push_ev;
    sw_event_t        head_ev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw_i;
            s2_q <= s1_q;
        end
    end

    // Counter saturates at CNT_LAST; a vector qualifies once it has sat there unchanged.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        qualify  = 1'b0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cand_q != stable_q) begin
            qualify  = 1'b1;
            stable_d = cand_q;
        end
    end

    assign push_ev = make_event(cand_q, stable_q);
    assign pop     = ev_valid_o & ev_ready_i;
    assign drop    = qualify & fifo_full & ~pop;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ov_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q     <= '0;
            cnt_q      <= '0;
            stable_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            overflow_q <= overflow_d;
        end
    end

    ev_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ev_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (qualify),
        .data_i  (push_ev),
        .pop_i   (pop),
        .data_o  (head_ev),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign stable_o   = stable_q;
    assign ev_valid_o = ~fifo_empty;
    assign ev_sw_o    = head_ev.sw;
    assign ev_rise_o  = head_ev.rise;
    assign ev_fall_o  = head_ev.fall;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_sw_event_reader.sv
// Bench for sw_event_reader: directed scenarios with literal expectations plus randomized traffic vs a run-length model.
module tb_sw_event_reader;
    import sw_event_reader_pkg::*;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       ev_ready = 1'b0;
    logic       ov_clr = 1'b0;
    logic [7:0] stable, ev_sw, ev_rise, ev_fall;
    logic       ev_valid, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    sw_event_reader #(
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_i       (sw),
        .stable_o   (stable),
        .ev_valid_o (ev_valid),
        .ev_ready_i (ev_ready),
        .ev_sw_o    (ev_sw),
        .ev_rise_o  (ev_rise),
        .ev_fall_o  (ev_fall),
        .overflow_o (overflow),
        .ov_clr_i   (ov_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: a vector qualifies once the synchronized input has held one value
    // for DEB+1 consecutive cycles and differs from the current stable vector.
    logic [7:0] m_s1, m_s2, m_stable;
    int         m_run;
    sw_event_t  m_q[$];
    logic       m_ov;
    bit         m_live = 1'b0;
    int         m_sz;
    bit         m_pop, m_qual, m_drop;
    sw_event_t  m_ev;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 8'h00; m_s2 = 8'h00; m_stable = 8'h00;
            m_run = 1; m_q.delete(); m_ov = 1'b0; m_live = 1'b1;
        end else begin
            m_sz   = m_q.size();
            m_pop  = (m_sz > 0) && ev_ready;
            m_qual = (m_run >= DEB + 1) && (m_s2 != m_stable);
            m_drop = 1'b0;
            if (m_pop) void'(m_q.pop_front());
            if (m_qual) begin
                m_ev.sw   = m_s2;
                m_ev.rise = m_s2 & ~m_stable;
                m_ev.fall = ~m_s2 & m_stable;
                if (m_sz < DEPTH || m_pop) m_q.push_back(m_ev);
                else m_drop = 1'b1;
                m_stable = m_s2;
            end
            if (m_drop) m_ov = 1'b1;
            else if (ov_clr) m_ov = 1'b0;
            if (m_s1 == m_s2) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            m_s2 = m_s1;
            m_s1 = sw;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_stable", {24'h0, stable}, {24'h0, m_stable});
            chk("m_ev_valid", {31'h0, ev_valid}, {31'h0, m_q.size() > 0});
            chk("m_ev_sw", {24'h0, ev_sw}, (m_q.size() > 0) ? {24'h0, m_q[0].sw} : 32'h0);
            chk("m_ev_rise", {24'h0, ev_rise}, (m_q.size() > 0) ? {24'h0, m_q[0].rise} : 32'h0);
            chk("m_ev_fall", {24'h0, ev_fall}, (m_q.size() > 0) ? {24'h0, m_q[0].fall} : 32'h0);
            chk("m_overflow", {31'h0, overflow}, {31'h0, m_ov});
        end
    end

    task automatic drain_expect(input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3, input string tag);
        logic [7:0] exp_list [4];
        exp_list[0] = e0; exp_list[1] = e1; exp_list[2] = e2; exp_list[3] = e3;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_valid"}, {31'h0, ev_valid}, 32'h1);
            chk({tag, "_order"}, {24'h0, ev_sw}, {24'h0, exp_list[i]});
            ev_ready = 1'b1;
            cyc(1);
            ev_ready = 1'b0;
        end
        chk({tag, "_empty"}, {31'h0, ev_valid}, 32'h0);
    endtask

    logic [7:0] seq [5];
    int         hold;

    initial begin
        rst = 1'b1; sw = 8'h00; ev_ready = 1'b0; ov_clr = 1'b0;
        cyc(3);
        chk("rst_stable", {24'h0, stable}, 32'h0);
        chk("rst_valid", {31'h0, ev_valid}, 32'h0);
        chk("rst_ev_sw", {24'h0, ev_sw}, 32'h0);
        chk("rst_overflow", {31'h0, overflow}, 32'h0);

        // First change: latency of DEB+3 edges
        rst = 1'b0; sw = 8'h01;
        cyc(6);
        chk("lat_edge6_valid", {31'h0, ev_valid}, 32'h0);
        cyc(1);
        chk("lat_edge7_valid", {31'h0, ev_valid}, 32'h1);
        chk("lat_ev_sw", {24'h0, ev_sw}, 32'h01);
        chk("lat_ev_rise", {24'h0, ev_rise}, 32'h01);
        chk("lat_ev_fall", {24'h0, ev_fall}, 32'h00);
        chk("lat_stable", {24'h0, stable}, 32'h01);
        ev_ready = 1'b1; cyc(1); ev_ready = 1'b0;
        chk("pop_empty", {31'h0, ev_valid}, 32'h0);

        // Short pulse must be filtered
        sw = 8'h03; cyc(3); sw = 8'h01; cyc(12);
        chk("glitch_stable", {24'h0, stable}, 32'h01);
        chk("glitch_valid", {31'h0, ev_valid}, 32'h0);

        // Five events into a four-deep queue
        seq[0] = 8'h02; seq[1] = 8'h04; seq[2] = 8'h08; seq[3] = 8'h10; seq[4] = 8'h20;
        for (int i = 0; i < 5; i++) begin
            sw = seq[i]; cyc(8);
        end
        chk("ovf_set", {31'h0, overflow}, 32'h1);
        chk("ovf_stable", {24'h0, stable}, 32'h20);
        chk("ovf_head_rise", {24'h0, ev_rise}, 32'h02);
        chk("ovf_head_fall", {24'h0, ev_fall}, 32'h01);
        ov_clr = 1'b1; cyc(1); ov_clr = 1'b0;
        chk("ovf_clr", {31'h0, overflow}, 32'h0);
        drain_expect(8'h02, 8'h04, 8'h08, 8'h10, "ovf_drain");

        // Full queue, push coincides with pop
        seq[0] = 8'h40; seq[1] = 8'h80; seq[2] = 8'h01; seq[3] = 8'h02;
        for (int i = 0; i < 4; i++) begin
            sw = seq[i]; cyc(8);
        end
        sw = 8'h04;
        cyc(6);
        chk("full_head", {24'h0, ev_sw}, 32'h40);
        ev_ready = 1'b1; cyc(1); ev_ready = 1'b0;
        chk("full_pushpop_ovf", {31'h0, overflow}, 32'h0);
        chk("full_pushpop_stable", {24'h0, stable}, 32'h04);
        drain_expect(8'h80, 8'h01, 8'h02, 8'h04, "full_drain");

        // Reset mid-debounce with sw held high
        sw = 8'hFF; cyc(3);
        rst = 1'b1; cyc(1);
        chk("mid_rst_stable", {24'h0, stable}, 32'h0);
        chk("mid_rst_valid", {31'h0, ev_valid}, 32'h0);
        chk("mid_rst_ev_sw", {24'h0, ev_sw}, 32'h0);
        chk("mid_rst_ev_rise", {24'h0, ev_rise}, 32'h0);
        chk("mid_rst_ev_fall", {24'h0, ev_fall}, 32'h0);
        chk("mid_rst_ovf", {31'h0, overflow}, 32'h0);
        cyc(1);
        rst = 1'b0;
        cyc(6);
        chk("post_rst_edge6", {31'h0, ev_valid}, 32'h0);
        cyc(1);
        chk("post_rst_valid", {31'h0, ev_valid}, 32'h1);
        chk("post_rst_ev_sw", {24'h0, ev_sw}, 32'hFF);
        chk("post_rst_ev_rise", {24'h0, ev_rise}, 32'hFF);
        chk("post_rst_ev_fall", {24'h0, ev_fall}, 32'h00);
        ev_ready = 1'b1; cyc(1); ev_ready = 1'b0;
        cyc(2);
        chk("post_rst_single", {31'h0, ev_valid}, 32'h0);

        // Randomized traffic checked by the model every cycle
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
                else sw = sw ^ (8'h01 << $urandom_range(0, 7));
                hold = $urandom_range(1, 10);
            end else begin
                hold--;
            end
            ev_ready = ($urandom_range(0, 3) == 0);
            ov_clr   = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 1'b0; ev_ready = 1'b0; ov_clr = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_event_reader.md
SW_EVENT_READER -- requirements
Module: sw_event_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable-time in clk cycles before a switch vector is accepted; legal range 2..2^24-1.
REQ-002 Parameter FIFO_DEPTH, default 4, event queue entries; power of two, 2..16.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sw  input  8  raw asynchronous switch levels.
REQ-006 stable  output  8  current debounced switch vector.
REQ-007 ev_valid  output  1  event queue non-empty; head event presented.
REQ-008 ev_ready  input  1  consumer accepts head event when high with ev_valid.
REQ-009 ev_sw  output  8  debounced vector after the change, head event.
REQ-010 ev_rise  output  8  bits that went 0->1, head event.
REQ-011 ev_fall  output  8  bits that went 1->0, head event.
REQ-012 overflow  output  1  sticky: an event was dropped because the queue was full.
REQ-013 ov_clr  input  1  clears overflow.

Function
REQ-014 sw SHALL pass a 2-flop synchronizer (s1, s2) before any other use; no logic on s1.
REQ-015 Candidate register cand and counter cnt (24 bit): if s2 != cand then cand <= s2, cnt <= 0; else if cnt < DEBOUNCE_CYCLES-1 then cnt <= cnt+1; else cnt holds (saturates).
REQ-016 When s2 == cand, cnt == DEBOUNCE_CYCLES-1 and cand != stable, stable <= cand and one event {cand, cand & ~stable, ~cand & stable} SHALL be pushed in the same edge.
REQ-017 Latency: sw changed and held; stable updates and ev_valid rises after exactly DEBOUNCE_CYCLES+3 rising edges (queue initially empty).
REQ-018 Any sw glitch shorter than DEBOUNCE_CYCLES cycles (after sync) SHALL produce no event and no stable change.
REQ-019 A change that returns to the prior stable value before qualifying SHALL produce no event.
REQ-020 Queue is FIFO ordered; ev_sw/ev_rise/ev_fall reflect head entry and are registered (no combinational path from sw).
REQ-021 Pop on ev_valid & ev_ready; ev_ready ignored when ev_valid low.
REQ-022 ev_valid and head fields SHALL remain stable until popped.
REQ-023 Push when full without simultaneous pop: event dropped, stable still updates, overflow <= 1.
REQ-024 Push and pop in the same cycle when full: both occur, no overflow, count unchanged.
REQ-025 Push and pop same cycle when empty: not applicable (ev_valid low); push only.
REQ-026 ov_clr and an overflow event in the same cycle: overflow SHALL be 1 (set wins).
REQ-027 Read/write pointers wrap modulo FIFO_DEPTH; full/empty from an extra pointer bit.

Reset
REQ-028 rst SHALL set s1, s2, cand, stable to 8'h00, cnt to 0, queue empty (ev_valid 0, ev_sw/ev_rise/ev_fall 0), overflow 0.
REQ-029 rst mid-operation SHALL discard queued events and any debounce in progress; a nonzero sw held through reset yields one event DEBOUNCE_CYCLES+3 edges after rst deasserts.

Structure
REQ-030 Event record layout (24 bits: sw, rise, fall) and field widths SHALL live in the shared package alongside the board I/O width constants.
REQ-031 Queue SHALL be one sub-module, ev_fifo (parameterized width/depth, push/pop/full/empty); debounce logic in sw_event_reader.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-032 Reset, sw 00->01 held -> ev_valid high after edge 7, ev_sw=01, ev_rise=01, ev_fall=00, stable=01.
REQ-033 sw 01 with 3-cycle pulse to 03 -> no event, stable stays 01, ev_valid stays 0.
REQ-034 ev_ready=0, five qualified changes 01->02->04->08->10->20 -> 4 events queued in order, fifth dropped, overflow=1, stable=20; ov_clr -> overflow=0.
REQ-035 Queue full, new event qualifies in same cycle as pop -> count stays 4, overflow stays 0, new event last in order.
REQ-036 sw=FF held, rst pulsed mid-debounce -> all outputs 0 during reset; one event ev_sw=FF, ev_rise=FF after edge 7 post-reset.
